// File: rtl/synth_pkg.sv
// Shared constants and types for the note synthesis chain.
// Phase arithmetic is in centi-Hz against a 100*SAMPLE_HZ modulus.
package synth_pkg;

    localparam int unsigned SAMPLE_HZ_DEF = 48000;
    localparam int unsigned MOD           = 100 * SAMPLE_HZ_DEF;
    localparam int unsigned PHASE_W       = $clog2(MOD);
    localparam int unsigned FREQ_W_DEF    = 21;

    typedef logic [FREQ_W_DEF-1:0] freq_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } osc_state_e;

    function automatic int unsigned phase_width(input int unsigned sample_hz);
        return $clog2(100 * sample_hz);
    endfunction

endpackage

// File: rtl/note_oscillator_if.sv
// Control/sample bundle between the oscillator and its driver and codec.
// Builds with VOLUME_EN carry an extra 4-bit volume control.
interface note_oscillator_if #(
    parameter int unsigned FREQ_W   = 21,
    parameter int unsigned SAMPLE_W = 24
);

    logic                       gate;
    logic [FREQ_W-1:0]          frequency;
    logic                       sample_req;
`ifdef VOLUME_EN
    logic [3:0]                 volume;
`endif
    logic signed [SAMPLE_W-1:0] sample;
    logic                       sample_valid;
    logic                       active;

`ifdef VOLUME_EN
    modport master (
        output gate, frequency, sample_req, volume,
        input  sample, sample_valid, active
    );
    modport slave (
        input  gate, frequency, sample_req, volume,
        output sample, sample_valid, active
    );
`else
    modport master (
        output gate, frequency, sample_req,
        input  sample, sample_valid, active
    );
    modport slave (
        input  gate, frequency, sample_req,
        output sample, sample_valid, active
    );
`endif

endinterface

// File: rtl/phase_accum.sv
// Exact modulo phase accumulator: phase steps by incr, wrapping at MOD_P.
// wrap_o is combinational for the current phase+incr; half_o marks phase >= MOD_P/2.
module phase_accum
    import synth_pkg::*;
#(
    parameter int unsigned MOD_P = MOD,
    parameter int unsigned PW    = PHASE_W,
    parameter int unsigned INC_W = $bits(freq_t)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_i,
    input  logic             clear_i,
    input  logic [INC_W-1:0] incr_i,
    output logic             wrap_o,
    output logic             half_o
);

    localparam logic [PW:0]   MOD_V  = MOD_P[PW:0];
    localparam logic [PW-1:0] HALF_V = MOD_V[PW:1];

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;
    logic [PW:0]   sum;
    logic [PW:0]   sum_red;

    // One guard bit keeps phase+incr exact before the modulo subtract.
    always_comb begin
        sum     = {1'b0, phase_q} + {{(PW + 1 - INC_W){1'b0}}, incr_i};
        sum_red = sum - MOD_V;
        wrap_o  = (sum >= MOD_V);
        phase_d = phase_q;
        if (clear_i) begin
            phase_d = '0;
        end else if (step_i) begin
            phase_d = wrap_o ? sum_red[PW-1:0] : sum[PW-1:0];
        end
    end

    assign half_o = (phase_q >= HALF_V);

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/note_oscillator.sv
// Gated square-wave oscillator; retune/volume/note-off land on period wraps.
// Optional VOLUME_EN adds a 4-bit volume latched with the frequency.
module note_oscillator
    import synth_pkg::*;
#(
    parameter int unsigned SAMPLE_HZ = SAMPLE_HZ_DEF,
    parameter int unsigned FREQ_W    = $bits(freq_t),
    parameter int unsigned SAMPLE_W  = 24,
    parameter int unsigned AMPLITUDE = 1048576
) (
    input  logic             clk,
    input  logic             reset,
    note_oscillator_if.slave bus
);

    localparam int unsigned MOD_L = 100 * SAMPLE_HZ;
    localparam int unsigned PW    = phase_width(SAMPLE_HZ);
    localparam logic signed [SAMPLE_W-1:0] AMP_V =
        $signed(AMPLITUDE[SAMPLE_W-1:0]);

    osc_state_e                 state_q;
    osc_state_e                 state_d;
    logic [FREQ_W-1:0]          freq_q;
    logic [FREQ_W-1:0]          freq_d;
    logic signed [SAMPLE_W-1:0] sample_q;
    logic signed [SAMPLE_W-1:0] sample_d;
    logic                       valid_q;
    logic                       valid_d;
    logic signed [SAMPLE_W-1:0] mag;

    logic step;
    logic clear;
    logic latch;
    logic wrap;
    logic wrapped;
    logic half;
    logic stalled;

    phase_accum #(
        .MOD_P (MOD_L),
        .PW    (PW),
        .INC_W (FREQ_W)
    ) u_acc (
        .clk     (clk),
        .reset   (reset),
        .step_i  (step),
        .clear_i (clear),
        .incr_i  (freq_q),
        .wrap_o  (wrap),
        .half_o  (half)
    );

    assign stalled = (freq_q == '0);
    assign wrapped = bus.sample_req & wrap;

`ifdef VOLUME_EN
    logic [3:0] vol_q;
    logic [3:0] vol_d;

    assign vol_d = latch ? bus.volume : vol_q;
    assign mag   = (vol_q == 4'd0) ? '0 : (AMP_V >>> (4'd15 - vol_q));

    always_ff @(posedge clk) begin
        if (!reset) begin
            vol_q <= '0;
        end else begin
            vol_q <= vol_d;
        end
    end
`else
    assign mag = AMP_V;
`endif

    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        step     = 1'b0;
        clear    = 1'b0;
        latch    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.sample_req) begin
                    sample_d = '0;
                    valid_d  = 1'b1;
                end
                if (bus.gate) begin
                    state_d = RUN;
                    clear   = 1'b1;
                    latch   = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (bus.sample_req) begin
                    step     = 1'b1;
                    valid_d  = 1'b1;
                    sample_d = stalled ? '0 : (half ? -mag : mag);
                    // A stalled (zero-step) note keeps re-sampling its frequency.
                    latch    = wrap | stalled;
                end
                if (state_q == RUN) begin
                    if (!bus.gate) begin
                        state_d = wrapped ? IDLE : DRAIN;
                    end
                end else if (bus.gate) begin
                    state_d = RUN;
                end else if (wrapped) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign freq_d = latch ? bus.frequency : freq_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            freq_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            freq_q   <= freq_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.active       = (state_q != IDLE);

endmodule

// File: tb/tb_note_oscillator.sv
// Directed plus randomized bench for note_oscillator against an arithmetic model.
// Build with +define+VOLUME_EN to also cover the volume control.
module tb_note_oscillator;

    localparam longint AMP  = 1048576;
    localparam longint MODL = 4800000;

    logic clk;
    logic reset;

    note_oscillator_if bus_if ();

    note_oscillator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: 0 = silent, 1 = held, 2 = releasing
    int     m_st;
    longint m_ph;
    longint m_fr;
    longint exp_s;
    bit     exp_v;
`ifdef VOLUME_EN
    int     m_vol;
`endif

    function automatic longint mag();
`ifdef VOLUME_EN
        if (m_vol == 0) return 0;
        return AMP >> (15 - m_vol);
`else
        return AMP;
`endif
    endfunction

    task automatic latch_note();
        m_fr = longint'(bus_if.frequency);
`ifdef VOLUME_EN
        m_vol = int'(bus_if.volume);
`endif
    endtask

    task automatic model_step();
        bit     wrap;
        longint sum;
        wrap = 1'b0;
        if (!reset) begin
            m_st  = 0;
            m_ph  = 0;
            m_fr  = 0;
            exp_s = 0;
            exp_v = 1'b0;
        end else begin
            exp_v = bus_if.sample_req;
            if (bus_if.sample_req) begin
                if (m_st == 0 || m_fr == 0) exp_s = 0;
                else exp_s = (m_ph < MODL / 2) ? mag() : -mag();
                if (m_st != 0) begin
                    sum  = m_ph + m_fr;
                    wrap = (sum >= MODL);
                    m_ph = sum % MODL;
                    if (wrap || m_fr == 0) latch_note();
                end
            end
            case (m_st)
                0: if (bus_if.gate) begin
                    m_st = 1;
                    m_ph = 0;
                    latch_note();
                end
                1: if (!bus_if.gate) m_st = wrap ? 0 : 2;
                default: begin
                    if (bus_if.gate) m_st = 1;
                    else if (wrap) m_st = 0;
                end
            endcase
        end
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("sample", longint'(bus_if.sample), exp_s);
        check("valid", longint'(bus_if.sample_valid), longint'(exp_v));
        check("active", longint'(bus_if.active), longint'(m_st != 0));
    endtask

    task automatic request(input int gap);
        bus_if.sample_req = 1'b1;
        tick();
        bus_if.sample_req = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        longint      s;
        int unsigned pick;
        reset             = 1'b0;
        bus_if.gate       = 1'b0;
        bus_if.frequency  = '0;
        bus_if.sample_req = 1'b0;
`ifdef VOLUME_EN
        bus_if.volume     = 4'd15;
`endif
        tick();
        tick();
        check("rst_sample", longint'(bus_if.sample), 0);
        check("rst_active", longint'(bus_if.active), 0);

        // Steady 440 Hz tone
        reset            = 1'b1;
        bus_if.gate      = 1'b1;
        bus_if.frequency = 21'd44000;
        tick();
        for (int k = 1; k <= 112; k++) begin
            request(1);
            s = longint'(bus_if.sample);
            if (k == 1)   check("steady_first", s, AMP);
            if (k == 55)  check("steady_last_pos", s, AMP);
            if (k == 56)  check("steady_first_neg", s, -AMP);
            if (k == 110) check("steady_wrap_req", s, -AMP);
            if (k == 111) check("steady_after_wrap", s, AMP);
        end

        // Release after request 30; silence only after the wrap
        pulse_reset();
        tick();
        for (int k = 1; k <= 113; k++) begin
            if (k == 31) bus_if.gate = 1'b0;
            request(1);
            if (k == 60)  check("drain_active", longint'(bus_if.active), 1);
            if (k == 110) check("release_idle", longint'(bus_if.active), 0);
            if (k > 110)  check("release_zero", longint'(bus_if.sample), 0);
        end

        // Retune mid-period is deferred to the wrap
        bus_if.gate = 1'b1;
        tick();
        for (int k = 1; k <= 112; k++) begin
            if (k == 20) bus_if.frequency = 21'd88000;
            request(0);
            if (k == 111) check("retune_ph1", longint'(dut.u_acc.phase_q), 128000);
            if (k == 112) check("retune_ph2", longint'(dut.u_acc.phase_q), 216000);
        end
        repeat (21) request(0);

        // Reset in the middle of a note
        reset = 1'b0;
        tick();
        check("midrst_sample", longint'(bus_if.sample), 0);
        check("midrst_valid", longint'(bus_if.sample_valid), 0);
        check("midrst_active", longint'(bus_if.active), 0);
        reset            = 1'b1;
        bus_if.frequency = 21'd44000;
        tick();
        request(0);
        check("restart_pos", longint'(bus_if.sample), AMP);
        check("restart_ph", longint'(dut.u_acc.phase_q), 44000);

        // Back-to-back requests
        bus_if.sample_req = 1'b1;
        tick();
        check("b2b_v1", longint'(bus_if.sample_valid), 1);
        tick();
        check("b2b_v2", longint'(bus_if.sample_valid), 1);
        bus_if.sample_req = 1'b0;
        tick();
        check("b2b_ph", longint'(dut.u_acc.phase_q), 132000);

        // Zero-frequency note picks up a later frequency
        bus_if.frequency = '0;
        pulse_reset();
        tick();
        repeat (3) request(1);
        bus_if.frequency = 21'd44000;
        request(1);
        check("stall_zero", longint'(bus_if.sample), 0);
        request(1);
        check("stall_start", longint'(bus_if.sample), AMP);

`ifdef VOLUME_EN
        bus_if.volume = 4'd14;
        pulse_reset();
        tick();
        request(1);
        check("vol14", longint'(bus_if.sample), 524288);
        bus_if.volume = 4'd0;
        pulse_reset();
        tick();
        repeat (5) begin
            request(0);
            check("vol0_zero", longint'(bus_if.sample), 0);
            check("vol0_active", longint'(bus_if.active), 1);
        end
        bus_if.volume = 4'd15;
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 39) == 0) bus_if.gate = ~bus_if.gate;
            if ($urandom_range(0, 99) < 3) begin
                pick = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(50000, 2000000);
                bus_if.frequency = 21'(pick);
            end
`ifdef VOLUME_EN
            if ($urandom_range(0, 49) == 0) bus_if.volume = 4'($urandom_range(0, 15));
`endif
            bus_if.sample_req = ($urandom_range(0, 1) == 1);
            tick();
        end
        bus_if.sample_req = 1'b0;
        reset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_oscillator.md
Name: note_oscillator

Overview:
- Sits directly downstream of the note-to-frequency lookup.
- Consumes its frequency word (centi-Hz, i.e. Hz×100) and produces a square-wave audio sample stream for the audio-codec output path.
- Uses an exact modulo phase accumulator in centi-Hz units, advanced once per codec sample request.
- Gate-controlled; retune, volume change and note-off take effect only at period boundaries, so there are no clicks.

Parameters:
- SAMPLE_HZ, 48000, codec sample rate; the phase modulus is MOD = 100*SAMPLE_HZ (4,800,000 at default).
- FREQ_W, 21, width of the frequency input in centi-Hz.
- SAMPLE_W, 24, width of the signed output sample.
- AMPLITUDE, 1048576, positive peak magnitude of the square wave.

Ports:
- Clock and reset (already decided): one clock, `clk`; reset port `reset`, synchronous and active-low.
- clk  input  1  system clock.
- reset  input  1  synchronous active-low reset.
- gate  input  1  note held (1) / released (0).
- frequency  input  FREQ_W  tone frequency in centi-Hz, unsigned; 0 means silence.
- sample_req  input  1  one-cycle pulse from the codec requesting the next sample.
- sample  output  SAMPLE_W  signed two's-complement sample, registered.
- sample_valid  output  1  one-cycle pulse: sample is valid.
- active  output  1  high while state != IDLE.

Behaviour:
- Reset values (reset==0 at a clk edge):
  - state=IDLE; phase=0; freq_reg=0.
  - sample=0; sample_valid=0; active=0.
  - Reset overrides all other inputs the same cycle.
- Reset mid-operation: abort immediately; no drain.
- States:
  - IDLE: sample request answered with sample=0. gate==1 → RUN with phase←0 and freq_reg←frequency.
  - RUN: a wrap with gate==0 → IDLE. gate==0 without a wrap → DRAIN.
  - DRAIN: keep producing the waveform. gate==1 → RUN, phase not reset. Wrap with gate==0 → IDLE.
- Per sample_req in RUN or DRAIN:
  - sum = phase + freq_reg, computed at ceil(log2 MOD)+1 bits.
  - If sum >= MOD: phase←sum−MOD and wrap=1. Otherwise phase←sum.
  - Output level uses the pre-update phase: phase < MOD/2 → +AMPLITUDE, else −AMPLITUDE. The first sample after gate-on is therefore +AMPLITUDE.
  - On wrap: freq_reg←frequency. This is the only retune point.
  - If freq_reg==0: output 0, and freq_reg←frequency on every request so a stalled note can start.
- Latency:
  - sample and sample_valid update on the edge after the sample_req edge.
  - sample_valid is high exactly one cycle per request.
  - Back-to-back requests on consecutive cycles are each served; there is no dropping and no queueing.
- No sample_req: phase, sample and state hold; gate transitions are still tracked.
- frequency >= MOD/2 (above Nyquist) is out of contract. No clamping; the modulo stays correct.

Optional Feature:
- Macro: VOLUME_EN.
- Defined:
  - Adds input volume, 4 bits.
  - Magnitude = AMPLITUDE >>> (15−vol_reg); vol_reg==0 forces the sample to 0.
  - vol_reg is latched at gate-on and at each wrap, together with freq_reg.
- Undefined: no volume port; magnitude is always AMPLITUDE.

Decomposition:
- Package synth_pkg holds:
  - the MOD constant and the phase-width localparam;
  - the state enum {IDLE, RUN, DRAIN};
  - the centi-Hz frequency typedef shared with the lookup stage.
- Sub-module phase_accum:
  - inputs: step enable, increment, clear;
  - outputs: phase, wrap flag (combinational), half flag.
- The FSM and output register stay in note_oscillator.

Test Plan:
- Steady tone: reset; gate=1, frequency=44000 (440 Hz); issue 110 sample_req → samples 0–54 = +1048576, samples 55–109 = −1048576. The 110th request wraps with phase=40000, and the next sample is +1048576.
- Release: gate=0 after request 30 → active stays 1 and the waveform continues. On request 110 (wrap): state IDLE, active=0, all later samples 0, each with its sample_valid pulse.
- Retune: change frequency to 88000 at request 20 → step stays 44000 until the wrap on request 110. From then on the step is 88000: next phase=128000, then 216000.
- Reset mid-note: reset=0 for one cycle during RUN with phase≈2,000,000 → next cycle sample=0, sample_valid=0, active=0. A later gate=1 restarts from phase 0.
- Back-to-back: sample_req high on 2 consecutive cycles, frequency=44000 → two sample_valid pulses on consecutive cycles; phase advances by 88000 total.
- VOLUME_EN: volume=14, frequency=44000 → first sample +524288. volume=0 → all samples 0 while active=1.
